// File: rtl/freq_pkg.sv
// Shared types and defaults for the gated frequency meter.
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2
    } state_t;

    localparam int DEF_GATE_CYCLES = 1000;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 3;

    // Timer only has to reach GATE_CYCLES-1.
    function automatic int timer_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// Synchroniser, optional agreement filter (FREQ_GLITCH_FILTER_EN) and registered rising-edge pulse.
module freq_edge_sync #(
    parameter int SYNC_STAGES = 2
`ifdef FREQ_GLITCH_FILTER_EN
    , parameter int FILT_LEN  = 3
`endif
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lvl;
    logic                   r_lvl_d;
    logic                   r_pulse;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_sync <= '0;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
    end

`ifdef FREQ_GLITCH_FILTER_EN
    // Level only moves once FILT_LEN consecutive samples agree.
    logic [FILT_LEN-2:0] r_hist;
    logic [FILT_LEN-1:0] w_win;
    logic                r_filt;

    assign w_win = {r_hist, r_sync[SYNC_STAGES-1]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hist <= '0;
            r_filt <= 1'b0;
        end else begin
            r_hist <= w_win[FILT_LEN-2:0];
            if (&w_win)       r_filt <= 1'b1;
            else if (~|w_win) r_filt <= 1'b0;
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lvl_d <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;
            r_pulse <= w_lvl & ~r_lvl_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/freq_gate_meter.sv
// Gated edge counter: IDLE/ARM/GATE FSM, saturating count, valid/ready result with sticky overrun.
// Build option: FREQ_GLITCH_FILTER_EN enables the input agreement filter.
module freq_gate_meter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_sig_in,
    output logic [CNT_W-1:0] o_result,
    output logic             o_result_sat,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_overrun,
    output logic             o_gate_active
);

`ifdef FREQ_GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    // ARM lasts as long as the pulse path latency so stale samples never reach the counter.
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + (FILT_EN ? FILT_LEN : 0);
    localparam int TW         = timer_w(GATE_CYCLES);
    localparam int AW         = $clog2(ARM_CYCLES + 1);

    localparam logic [TW-1:0]    TIMER_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [AW-1:0]    ARM_LAST   = AW'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_arm_cnt;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_cnt, w_cnt_inc;
    logic [CNT_W-1:0] r_result;
    logic             r_sat, r_valid, r_overrun;
    logic             w_pulse, w_close;

    freq_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef FREQ_GLITCH_FILTER_EN
        , .FILT_LEN (FILT_LEN)
`endif
    ) u_edge (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_sig  (i_sig_in),
        .o_pulse(w_pulse)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_en) w_state_nxt = ARM;
            ARM:     if (!i_en) w_state_nxt = IDLE;
                     else if (r_arm_cnt == ARM_LAST) w_state_nxt = GATE;
            GATE:    if (!i_en) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_close   = (r_state == GATE) && i_en && (r_timer == TIMER_LAST);
    assign w_cnt_inc = (w_pulse && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_arm_cnt <= '0;
            r_timer   <= '0;
            r_cnt     <= '0;
        end else begin
            r_arm_cnt <= (r_state == ARM && w_state_nxt == ARM) ? r_arm_cnt + 1'b1 : '0;
            if (r_state == GATE && i_en) begin
                r_timer <= w_close ? '0 : r_timer + 1'b1;
                r_cnt   <= w_close ? '0 : w_cnt_inc;
            end else begin
                r_timer <= '0;
                r_cnt   <= '0;
            end
        end
    end

    // A close in the same cycle as a consume keeps valid high with fresh data.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_result  <= '0;
            r_sat     <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_close) begin
                r_result <= w_cnt_inc;
                r_sat    <= (w_cnt_inc == CNT_MAX);
            end
            if (w_close)             r_valid <= 1'b1;
            else if (i_result_ready) r_valid <= 1'b0;
            if (r_state == IDLE)                            r_overrun <= 1'b0;
            else if (w_close && r_valid && !i_result_ready) r_overrun <= 1'b1;
        end
    end

    assign o_result       = r_result;
    assign o_result_sat   = r_sat;
    assign o_result_valid = r_valid;
    assign o_overrun      = r_overrun;
    assign o_gate_active  = (r_state == GATE);

endmodule
